// File: rtl/hpu_pkg.sv
// Shared HPU definitions: VRAM read-return owner encoding and VRAM region base addresses.
package hpu_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [15:0] TILE_OFFSET      = 16'h0000;
  localparam logic [15:0] NAMETABLE_OFFSET = 16'h1800;
  localparam logic [15:0] ATTR_OFFSET      = 16'h2700;
  localparam logic [15:0] PALETTE_OFFSET   = 16'h2AC0;

endpackage

// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: HPU fetch port, CPU and DMA handshake ports, stall counter and VRAM macro pins.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              hpu_req;
  logic [ADDR_W-1:0] hpu_addr;
  logic [DATA_W-1:0] hpu_data;

  logic              cpu_req,    dma_req;
  logic              cpu_we,     dma_we;
  logic [ADDR_W-1:0] cpu_addr,   dma_addr;
  logic [DATA_W-1:0] cpu_wdata,  dma_wdata;
  logic              cpu_ack,    dma_ack;
  logic              cpu_rvalid, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata,  dma_rdata;

  logic              stall_clr;
  logic [15:0]       stall_cnt;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requester/memory side of the arbiter.
  modport master (
    output hpu_req, hpu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dma_req, dma_we, dma_addr, dma_wdata, stall_clr, mem_rdata,
    input  hpu_data, cpu_ack, dma_ack, cpu_rvalid, dma_rvalid,
           cpu_rdata, dma_rdata, stall_cnt, mem_addr, mem_we, mem_wdata
  );

  // The arbiter itself.
  modport slave (
    input  hpu_req, hpu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dma_req, dma_we, dma_addr, dma_wdata, stall_clr, mem_rdata,
    output hpu_data, cpu_ack, dma_ack, cpu_rvalid, dma_rvalid,
           cpu_rdata, dma_rdata, stall_cnt, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_rr_arb2.sv
// Two-way round-robin between CPU and DMA; gnt[0] = CPU, gnt[1] = DMA, all zero while inhibited.
module vram_rr_arb2
  import hpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_cpu,
  input  logic       req_dma,
  input  logic       inhibit,
  output logic [1:0] gnt
);

  owner_t rr_last;

  always_comb begin
    // NOTE: default assignment first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    if (!inhibit) begin
      if (req_cpu && (!req_dma || rr_last == OWN_DMA)) gnt = 2'b01;
      else if (req_dma)                                gnt = 2'b10;
    end
  end

  // Reset to DMA so the first tie goes to the CPU.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset)       rr_last <= OWN_DMA;
    else if (gnt[0]) rr_last <= OWN_CPU;
    else if (gnt[1]) rr_last <= OWN_DMA;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: HPU has absolute priority, CPU and DMA share leftover cycles round-robin
// with tagged read returns two cycles after the ack.
module vram_arbiter
  import hpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  vram_arbiter_if.slave bus
);

  logic [1:0] gnt;
  owner_t     rd_owner, rd_next;
  logic       contention;

  // Reset also inhibits grants so acks and memory controls read as zero while it is held.
  vram_rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req_cpu (bus.cpu_req),
    .req_dma (bus.dma_req),
    .inhibit (bus.hpu_req | reset),
    .gnt     (gnt)
  );

  assign bus.cpu_ack  = gnt[0];
  assign bus.dma_ack  = gnt[1];
  assign bus.hpu_data = bus.mem_rdata;
  assign contention   = bus.hpu_req && (bus.cpu_req || bus.dma_req);

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    rd_next       = OWN_NONE;
    if (bus.hpu_req && !reset) begin
      bus.mem_addr = bus.hpu_addr;
    end else if (gnt[0]) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = bus.cpu_we;
      bus.mem_wdata = bus.cpu_wdata;
      if (!bus.cpu_we) rd_next = OWN_CPU;
    end else if (gnt[1]) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_we    = bus.dma_we;
      bus.mem_wdata = bus.dma_wdata;
      if (!bus.dma_we) rd_next = OWN_DMA;
    end
  end

  // rd_owner marks whose read is on mem_rdata this cycle; the return registers capture it at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner       <= OWN_NONE;
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.dma_rdata  <= '0;
      bus.stall_cnt  <= '0;
    end else begin
      rd_owner       <= rd_next;
      bus.cpu_rvalid <= (rd_owner == OWN_CPU);
      bus.dma_rvalid <= (rd_owner == OWN_DMA);
      if (rd_owner == OWN_CPU) bus.cpu_rdata <= bus.mem_rdata;
      if (rd_owner == OWN_DMA) bus.dma_rdata <= bus.mem_rdata;
      if (bus.stall_clr)
        bus.stall_cnt <= '0;
      else if (contention && bus.stall_cnt != 16'hFFFF)
        bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM macro model, random traffic against a transaction-level model,
// a vector table for the grant/mux rules, and hand-written multi-cycle corner cases.
module tb_vram_arbiter;
  import hpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  vram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // VRAM macro: synchronous, one-cycle read latency; unwritten locations hold a fixed pattern.
  logic [7:0] vram    [0:65535];
  bit         written [0:65535];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) begin
      vram[bus.mem_addr]    <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= written[bus.mem_addr] ? vram[bus.mem_addr] : init_val(bus.mem_addr);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.hpu_req   = 1'b0; bus.hpu_addr  = '0;
    bus.cpu_req   = 1'b0; bus.cpu_we    = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0; bus.dma_we    = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.stall_clr = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_ack"},    bus.cpu_ack,    0);
    check({tag, "_dma_ack"},    bus.dma_ack,    0);
    check({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
    check({tag, "_dma_rvalid"}, bus.dma_rvalid, 0);
    check({tag, "_cpu_rdata"},  bus.cpu_rdata,  0);
    check({tag, "_dma_rdata"},  bus.dma_rdata,  0);
    check({tag, "_mem_addr"},   bus.mem_addr,   0);
    check({tag, "_mem_we"},     bus.mem_we,     0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,  0);
    check({tag, "_stall_cnt"},  bus.stall_cnt,  0);
  endtask

  // Transaction-level reference: memory contents, outstanding read returns, last served requester.
  typedef struct {
    bit         to_dma;
    logic [7:0] data;
    int         due;
  } ret_t;

  logic [7:0] shadow [logic [15:0]];
  ret_t       pend   [$];

  function automatic logic [7:0] model_mem(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic random_test(input int n_cycles);
    bit         last_dma = 1'b1;
    int         exp_stall = 0;
    logic [7:0] exp_crd = 8'h00, exp_drd = 8'h00, hpu_exp = 8'h00;
    bit         hpu_prev = 1'b0, cpu_won = 1'b0, dma_won = 1'b0;
    for (int c = 0; c < n_cycles; c++) begin
      if (!bus.cpu_req || cpu_won) begin
        bus.cpu_req   = ($urandom_range(0, 2) != 0);
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = 16'($urandom_range(0, 15));
        bus.cpu_wdata = 8'($urandom);
      end
      if (!bus.dma_req || dma_won) begin
        bus.dma_req   = ($urandom_range(0, 2) != 0);
        bus.dma_we    = 1'($urandom_range(0, 1));
        bus.dma_addr  = 16'($urandom_range(0, 15));
        bus.dma_wdata = 8'($urandom);
      end
      bus.hpu_req   = ($urandom_range(0, 3) == 0);
      bus.hpu_addr  = 16'($urandom_range(0, 15));
      bus.stall_clr = ($urandom_range(0, 31) == 0);
      @(negedge clk);

      if (hpu_prev) check("rnd_hpu_data", bus.hpu_data, hpu_exp);
      check("rnd_stall_cnt", bus.stall_cnt, exp_stall);

      begin
        bit exp_cv = 1'b0, exp_dv = 1'b0;
        if (pend.size() > 0 && pend[0].due == c) begin
          ret_t r = pend.pop_front();
          if (r.to_dma) begin exp_dv = 1'b1; exp_drd = r.data; end
          else          begin exp_cv = 1'b1; exp_crd = r.data; end
        end
        check("rnd_cpu_rvalid", bus.cpu_rvalid, exp_cv);
        check("rnd_dma_rvalid", bus.dma_rvalid, exp_dv);
        check("rnd_cpu_rdata",  bus.cpu_rdata,  exp_crd);
        check("rnd_dma_rdata",  bus.dma_rdata,  exp_drd);
      end

      // HPU first; otherwise a lone requester wins, and a tie goes to whoever was not served last.
      cpu_won = 1'b0;
      dma_won = 1'b0;
      if (!bus.hpu_req) begin
        if (bus.cpu_req && bus.dma_req) begin
          if (last_dma) cpu_won = 1'b1; else dma_won = 1'b1;
        end else begin
          cpu_won = bus.cpu_req;
          dma_won = bus.dma_req;
        end
      end
      check("rnd_cpu_ack", bus.cpu_ack, cpu_won);
      check("rnd_dma_ack", bus.dma_ack, dma_won);
      if (bus.hpu_req) begin
        check("rnd_mem_addr", bus.mem_addr, bus.hpu_addr);
        check("rnd_mem_we",   bus.mem_we,   0);
      end else if (cpu_won) begin
        check("rnd_mem_addr",  bus.mem_addr,  bus.cpu_addr);
        check("rnd_mem_we",    bus.mem_we,    bus.cpu_we);
        check("rnd_mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      end else if (dma_won) begin
        check("rnd_mem_addr",  bus.mem_addr,  bus.dma_addr);
        check("rnd_mem_we",    bus.mem_we,    bus.dma_we);
        check("rnd_mem_wdata", bus.mem_wdata, bus.dma_wdata);
      end else begin
        check("rnd_mem_addr",  bus.mem_addr,  0);
        check("rnd_mem_we",    bus.mem_we,    0);
        check("rnd_mem_wdata", bus.mem_wdata, 0);
      end

      if (cpu_won) begin
        last_dma = 1'b0;
        if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
        else pend.push_back('{to_dma: 1'b0, data: model_mem(bus.cpu_addr), due: c + 2});
      end
      if (dma_won) begin
        last_dma = 1'b1;
        if (bus.dma_we) shadow[bus.dma_addr] = bus.dma_wdata;
        else pend.push_back('{to_dma: 1'b1, data: model_mem(bus.dma_addr), due: c + 2});
      end
      hpu_prev = bus.hpu_req;
      hpu_exp  = model_mem(bus.hpu_addr);
      if (bus.stall_clr) exp_stall = 0;
      else if (bus.hpu_req && (bus.cpu_req || bus.dma_req) && exp_stall < 65535) exp_stall++;
      next_cycle();
    end
  endtask

  typedef struct {
    logic        hpu;  logic [15:0] haddr;
    logic        creq; logic cwe; logic [15:0] caddr; logic [7:0] cwd;
    logic        dreq; logic dwe; logic [15:0] daddr; logic [7:0] dwd;
    logic        e_cack; logic e_dack; logic [15:0] e_addr; logic e_we; logic [7:0] e_wd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with every requester asserting to show nothing leaks through.
    set_idle();
    reset       = 1'b1;
    bus.hpu_req = 1'b1; bus.hpu_addr = 16'h1234;
    bus.cpu_req = 1'b1; bus.dma_req  = 1'b1;
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    set_idle();

    random_test(2000);

    // Grant and mux rules from a known round-robin state (rr_last = DMA after reset).
    vecs[0] = '{0, 16'h0, 0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 0, 8'h00};
    vecs[1] = '{1, PALETTE_OFFSET, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0, 8'h00, 0, 0, PALETTE_OFFSET, 0, 8'h00};
    vecs[2] = '{0, 16'h0, 1, 0, 16'h0010, 8'h77, 1, 0, 16'h0011, 8'h00, 1, 0, 16'h0010, 0, 8'h77};
    vecs[3] = '{0, 16'h0, 1, 0, 16'h0010, 8'h00, 1, 1, 16'h0020, 8'hA5, 0, 1, 16'h0020, 1, 8'hA5};
    vecs[4] = '{0, 16'h0, 0, 0, 16'h0, 8'h00, 1, 0, 16'h0030, 8'h00, 0, 1, 16'h0030, 0, 8'h00};
    vecs[5] = '{0, 16'h0, 1, 0, 16'h0040, 8'h00, 1, 0, 16'h0031, 8'h00, 1, 0, 16'h0040, 0, 8'h00};
    vecs[6] = '{0, 16'h0, 1, 1, NAMETABLE_OFFSET, 8'h11, 0, 0, 16'h0, 8'h00, 1, 0, NAMETABLE_OFFSET, 1, 8'h11};
    vecs[7] = '{1, 16'h0100, 1, 0, 16'h0050, 8'h00, 1, 0, 16'h0051, 8'h00, 0, 0, 16'h0100, 0, 8'h00};
    vecs[8] = '{0, 16'h0, 1, 0, 16'h0050, 8'h00, 1, 1, 16'h0051, 8'h3F, 0, 1, 16'h0051, 1, 8'h3F};
    vecs[9] = '{0, 16'h0, 1, 0, TILE_OFFSET, 8'h00, 0, 0, 16'h0, 8'h00, 1, 0, TILE_OFFSET, 0, 8'h00};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.hpu_req = vecs[i].hpu;  bus.hpu_addr  = vecs[i].haddr;
      bus.cpu_req = vecs[i].creq; bus.cpu_we    = vecs[i].cwe;
      bus.cpu_addr = vecs[i].caddr; bus.cpu_wdata = vecs[i].cwd;
      bus.dma_req = vecs[i].dreq; bus.dma_we    = vecs[i].dwe;
      bus.dma_addr = vecs[i].daddr; bus.dma_wdata = vecs[i].dwd;
      @(negedge clk);
      check($sformatf("vec%0d_cpu_ack", i),   bus.cpu_ack,   vecs[i].e_cack);
      check($sformatf("vec%0d_dma_ack", i),   bus.dma_ack,   vecs[i].e_dack);
      check($sformatf("vec%0d_mem_addr", i),  bus.mem_addr,  vecs[i].e_addr);
      check($sformatf("vec%0d_mem_we", i),    bus.mem_we,    vecs[i].e_we);
      check($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, vecs[i].e_wd);
      next_cycle();
    end

    // CPU write then read-back of the same address.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = NAMETABLE_OFFSET; bus.cpu_wdata = 8'h5A;
    @(negedge clk); check("wr_cpu_ack", bus.cpu_ack, 1);
    next_cycle();
    bus.cpu_we = 1'b0;
    @(negedge clk); check("rd_cpu_ack", bus.cpu_ack, 1);
    next_cycle();
    set_idle();
    @(negedge clk); check("rd_rvalid_t1", bus.cpu_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("rd_rvalid_t2", bus.cpu_rvalid, 1);
    check("rd_rdata_t2",  bus.cpu_rdata,  8'h5A);
    next_cycle();
    @(negedge clk);
    check("rd_rvalid_t3", bus.cpu_rvalid, 0);
    check("rd_rdata_held", bus.cpu_rdata, 8'h5A);

    // CPU and DMA both reading continuously: acks and returns alternate.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0100;
    bus.dma_req = 1'b1; bus.dma_addr = 16'h0200;
    for (int k = 0; k < 8; k++) begin
      bit exp_cv, exp_dv;
      if (k == 6) set_idle();
      @(negedge clk);
      if (k < 6) begin
        check($sformatf("rr%0d_cpu_ack", k), bus.cpu_ack, (k % 2) == 0);
        check($sformatf("rr%0d_dma_ack", k), bus.dma_ack, (k % 2) == 1);
      end
      exp_cv = (k >= 2) && ((k - 2) % 2 == 0);
      exp_dv = (k >= 2) && ((k - 2) % 2 == 1);
      check($sformatf("rr%0d_cpu_rvalid", k), bus.cpu_rvalid, exp_cv);
      check($sformatf("rr%0d_dma_rvalid", k), bus.dma_rvalid, exp_dv);
      if (exp_cv) check($sformatf("rr%0d_cpu_rdata", k), bus.cpu_rdata, init_val(16'h0100));
      if (exp_dv) check($sformatf("rr%0d_dma_rdata", k), bus.dma_rdata, init_val(16'h0200));
      next_cycle();
    end

    // Nine HPU cycles starve a pending CPU read, which is granted right after.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0300;
    for (int k = 0; k < 9; k++) begin
      bus.hpu_req  = 1'b1;
      bus.hpu_addr = 16'h1000 + 16'(k);
      @(negedge clk);
      check($sformatf("hpu%0d_cpu_ack", k),  bus.cpu_ack,  0);
      check($sformatf("hpu%0d_mem_addr", k), bus.mem_addr, 16'h1000 + 16'(k));
      next_cycle();
    end
    bus.hpu_req = 1'b0;
    @(negedge clk);
    check("hpu_end_cpu_ack", bus.cpu_ack,   1);
    check("hpu_end_stall",   bus.stall_cnt, 9);
    next_cycle();

    // HPU read of attribute memory: one-cycle latency, no requester returns.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = ATTR_OFFSET; bus.cpu_wdata = 8'hC3;
    @(negedge clk); check("attr_wr_ack", bus.cpu_ack, 1);
    next_cycle();
    set_idle();
    bus.hpu_req = 1'b1; bus.hpu_addr = ATTR_OFFSET;
    @(negedge clk); check("attr_mem_addr", bus.mem_addr, ATTR_OFFSET);
    next_cycle();
    bus.hpu_req = 1'b0;
    @(negedge clk); check("attr_hpu_data", bus.hpu_data, 8'hC3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("attr%0d_cpu_rvalid", k), bus.cpu_rvalid, 0);
      check($sformatf("attr%0d_dma_rvalid", k), bus.dma_rvalid, 0);
      next_cycle();
      @(negedge clk);
    end

    // Reset lands while a DMA read is in flight: its return is dropped.
    do_reset();
    bus.dma_req = 1'b1; bus.dma_addr = 16'h0400;
    @(negedge clk); check("rstrd_dma_ack", bus.dma_ack, 1);
    next_cycle();
    reset = 1'b1;
    bus.cpu_req = 1'b1; bus.hpu_req = 1'b1; bus.hpu_addr = 16'h0404;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_all_zero($sformatf("rstrd%0d", k));
      next_cycle();
    end
    reset = 1'b0;
    bus.hpu_req = 1'b0;
    @(negedge clk);
    check("rstrd_tie_cpu_ack", bus.cpu_ack,    1);
    check("rstrd_tie_dma_ack", bus.dma_ack,    0);
    check("rstrd_dma_rvalid0", bus.dma_rvalid, 0);
    next_cycle();
    set_idle();
    @(negedge clk); check("rstrd_dma_rvalid1", bus.dma_rvalid, 0);
    next_cycle();

    // Stall counter saturation and clear-over-increment.
    do_reset();
    bus.hpu_req = 1'b1; bus.cpu_req = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    @(negedge clk); check("sat_reach", bus.stall_cnt, 16'hFFFF);
    next_cycle();
    @(negedge clk); check("sat_hold", bus.stall_cnt, 16'hFFFF);
    next_cycle();
    bus.stall_clr = 1'b1;
    @(negedge clk); check("sat_before_clr", bus.stall_cnt, 16'hFFFF);
    next_cycle();
    bus.stall_clr = 1'b0;
    @(negedge clk); check("sat_clr", bus.stall_cnt, 0);
    next_cycle();
    @(negedge clk); check("sat_restart", bus.stall_cnt, 1);
    set_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter that shares one synchronous 8-bit video memory between the HPU background fetcher and two lower-priority requesters: the host CPU port and the VRAM DMA engine. The HPU has absolute priority, is never stalled, and sees the memory exactly as if it were wired directly. CPU and DMA contend round-robin for the remaining cycles through a req/ack handshake, with tagged read returns. The block sits between hpu, the bus bridge and vram_dma, directly in front of the VRAM macro.

## Interface
- ADDR_W, 16, VRAM address width
- DATA_W, 8, VRAM data width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- hpu_req  in  1  HPU drives a valid read address this cycle
- hpu_addr  in  ADDR_W  HPU read address
- hpu_data  out  DATA_W  read data to HPU (= mem_rdata)
- cpu_req, dma_req  in  1  request, held until ack
- cpu_we, dma_we  in  1  1 = write, 0 = read
- cpu_addr, dma_addr  in  ADDR_W  access address
- cpu_wdata, dma_wdata  in  DATA_W  write data
- cpu_ack, dma_ack  out  1  access accepted this cycle
- cpu_rvalid, dma_rvalid  out  1  one-cycle pulse, read data valid
- cpu_rdata, dma_rdata  out  DATA_W  read data, held until next rvalid
- stall_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  16  saturating count of denied requester-cycles
- mem_addr  out  ADDR_W  VRAM address
- mem_we  out  1  VRAM write enable
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, 1-cycle latency

## Operation
- Grant is combinational per cycle: hpu_req > round-robin(cpu, dma) > idle.
- HPU grant: mem_addr = hpu_addr, mem_we = 0. cpu_ack and dma_ack are 0.
- Idle: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Round-robin: register rr_last (CPU/DMA). When both request, grant the port not equal to rr_last. A single requester is always granted. rr_last updates to the winner on every CPU/DMA grant.
- A granted port gets ack = 1 in the same cycle. mem_addr, mem_we and mem_wdata are muxed from that port. The requester drops req or presents its next access after the ack cycle.
- Read tracking: register rd_owner {NONE, CPU, DMA} is loaded with the winner on a granted read, otherwise NONE. In the following cycle the owner's rdata register captures mem_rdata. rvalid pulses one cycle later.
- hpu_data is driven from mem_rdata unconditionally. The HPU only samples it on the cycle after its own hpu_req.
- stall_cnt increments, saturating at 0xFFFF, each cycle with hpu_req && (cpu_req || dma_req). stall_clr takes precedence over increment.

## Timing
- Reset values:
  - rr_last = DMA, so CPU wins the first tie.
  - rd_owner = NONE.
  - All ack, rvalid, rdata, mem_we, mem_addr, mem_wdata and stall_cnt outputs are 0.
- Read latency: ack at cycle t, mem_rdata valid at t+1, rvalid and rdata at t+2. Back-to-back reads by one port give one rvalid per cycle.
- Write: committed at the ack cycle t. A read of the same address acked at t+1 returns the new data.
- HPU read latency is 1 cycle, identical to a direct connection.
- A CPU or DMA request pending under continuous hpu_req waits with ack = 0 and no timeout.
- A request and hpu_req both rising in the same cycle: HPU wins, and the request is granted in the first cycle hpu_req is low.
- Reset mid-read: the pending rvalid is dropped and rd_owner returns to NONE. In-flight data is lost.

## Structure
- Shared package hpu_pkg holds:
  - the owner enum {OWN_NONE, OWN_CPU, OWN_DMA};
  - the VRAM region constants TILE_OFFSET 16'h0000, NAMETABLE_OFFSET 16'h1800, ATTR_OFFSET 16'h2700, PALETTE_OFFSET 16'h2AC0.
- Sub-module vram_rr_arb2 contains the 2-way round-robin with its rr_last register. Inputs: req pair plus an inhibit (hpu_req). Outputs: one-hot grant.
- The top level holds the address/data muxes, rd_owner, the return registers and stall_cnt.

## Test plan
- CPU write 0x5A to 0x1800, then CPU read of 0x1800 with hpu_req low: cpu_ack on both requests, and cpu_rvalid 2 cycles after the read ack with cpu_rdata = 0x5A.
- cpu_req and dma_req held high for 6 cycles, both reads, hpu_req low: acks alternate CPU, DMA, CPU, …; each rvalid goes to the matching port with the correct data.
- hpu_req high for 9 cycles while cpu_req is pending: cpu_ack = 0 throughout, mem_addr tracks hpu_addr, stall_cnt = 9, and cpu_ack arrives in the first cycle after hpu_req falls.
- HPU read of 0x2700 containing 0xC3: hpu_data = 0xC3 exactly one cycle after hpu_req; neither cpu_rvalid nor dma_rvalid asserts.
- DMA read acked, then reset asserted in the next cycle: dma_rvalid never pulses, and all outputs are 0 during reset. After release, a DMA/CPU tie grants CPU first.
- stall_cnt forced to 0xFFFF by prolonged contention: it stays at 0xFFFF; stall_clr in the same cycle as contention yields 0.
